// File: rtl/gs_pattern_source.sv
// gs_pattern_source: produces the per-frame stream of 12-lane grayscale words
// for the pixel driver's shift chains, using a ready/valid handshake.
//
// Ports
//   clock, reset_n    : single clock, synchronous active-low reset
//   enable            : run request; acted on only in IDLE and at frame ends
//   mode[1:0]         : 0 SOLID, 1 RAMP, 2 BAR, 3 CHECKER (latched per frame)
//   level[7:0]        : SOLID intensity (latched per frame)
//   frame_pulse       : frame-boundary strobe from the pixel driver
//   out_ready         : consumer accepts the current word
//   out_valid/out_data/out_last : registered word output; lane l sits at
//                       out_data[l*GS_BITS +: GS_BITS]; out_last marks word WORDS-1
//   frame_count[15:0] : number of completed frames (wraps)
//   underrun          : sticky; a frame boundary arrived before the frame was
//                       fully delivered
//
// Build option: define GS_GAMMA_EN for square-law gamma, gs = (v*v) >> 4.
// Without it the 8-bit level is widened linearly, gs = {v, v[7:4]}.

module gs_pattern_lane #(
  parameter int LANE    = 0,
  parameter int BW      = 4,
  parameter int GS_BITS = 12
) (
  input  logic [1:0]         mode,
  input  logic [7:0]         level,
  input  logic [3:0]         chan,
  input  logic               w_lsb,
  input  logic [BW-1:0]      bar,
  input  logic               parity,
  output logic [GS_BITS-1:0] gs
);
  localparam logic [BW-1:0] LANE_IDX = BW'(LANE);
  localparam logic          LANE_ODD = (LANE % 2) == 1;

  logic [7:0] v;

  always_comb begin
    case (mode)
      2'd0:    v = level;
      2'd1:    v = {chan, chan};
      2'd2:    v = (bar == LANE_IDX) ? 8'hFF : 8'h00;
      default: v = (LANE_ODD ^ w_lsb ^ parity) ? 8'hFF : 8'h00;
    endcase
  end

`ifdef GS_GAMMA_EN
  logic [15:0] sq;
  assign sq = {8'd0, v} * {8'd0, v};
  assign gs = GS_BITS'(sq[15:4]);
`else
  assign gs = GS_BITS'({v, v[7:4]});
`endif
endmodule

module gs_pattern_source #(
  parameter int LANES   = 12,
  parameter int GS_BITS = 12,
  parameter int DEVICES = 1,
  parameter int WORDS   = 16 * DEVICES
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [7:0]               level,
  input  logic                     frame_pulse,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [LANES*GS_BITS-1:0] out_data,
  output logic                     out_last,
  output logic [15:0]              frame_count,
  output logic                     underrun
);
  localparam int              WW     = $clog2(WORDS);
  localparam int              BW     = $clog2(LANES);
  localparam logic [WW-1:0]   W_LAST = WW'(WORDS - 1);
  localparam logic [BW-1:0]   B_LAST = BW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, WAIT_FRAME} state_t;

  state_t                     state, state_n;
  logic [WW-1:0]              w, w_n, word_sel, chan;
  logic [1:0]                 mode_q, mode_q_n;
  logic [7:0]                 level_q, level_q_n;
  logic [BW-1:0]              bar, bar_n;
  logic                       parity, parity_n;
  logic                       fill_wait, fill_wait_n;
  logic                       out_valid_n, out_last_n, underrun_n;
  logic [LANES*GS_BITS-1:0]   out_data_n;
  logic [15:0]                frame_count_n;
  logic [LANES-1:0][GS_BITS-1:0] lane_gs;
  logic                       accept;

  assign accept = out_valid & out_ready;

  // Lanes always build the word that will be loaded next: word w while
  // filling, word w+1 while streaming (loaded on the accepting edge).
  assign word_sel = (state == STREAM) ? w + 1'b1 : w;
  // Channel order is reversed: word 0 carries the highest channel.
  assign chan     = W_LAST - word_sel;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gs_pattern_lane #(.LANE(l), .BW(BW), .GS_BITS(GS_BITS)) u_lane (
      .mode   (mode_q),
      .level  (level_q),
      .chan   (chan[3:0]),
      .w_lsb  (word_sel[0]),
      .bar    (bar),
      .parity (parity),
      .gs     (lane_gs[l])
    );
  end

  always_comb begin
    state_n       = state;
    w_n           = w;
    mode_q_n      = mode_q;
    level_q_n     = level_q;
    bar_n         = bar;
    parity_n      = parity;
    fill_wait_n   = fill_wait;
    out_valid_n   = out_valid;
    out_data_n    = out_data;
    out_last_n    = out_last;
    frame_count_n = frame_count;
    underrun_n    = underrun;

    case (state)
      IDLE: begin
        out_valid_n = 1'b0;
        out_last_n  = 1'b0;
        if (enable) begin
          state_n     = FILL;
          mode_q_n    = mode;
          level_q_n   = level;
          w_n         = '0;
          fill_wait_n = 1'b1;
        end
      end
      FILL: begin
        // First FILL cycle only settles; word 0 is loaded on the second, so
        // the first word appears two edges after the start/frame edge.
        if (fill_wait) begin
          fill_wait_n = 1'b0;
        end else begin
          out_valid_n = 1'b1;
          out_data_n  = lane_gs;
          out_last_n  = (word_sel == W_LAST);
          state_n     = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          if (w == W_LAST) begin
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            state_n     = WAIT_FRAME;
          end else begin
            w_n        = w + 1'b1;
            out_data_n = lane_gs;
            out_last_n = (word_sel == W_LAST);
          end
        end
      end
      WAIT_FRAME: begin
        if (frame_pulse) begin
          if (enable) begin
            state_n     = FILL;
            mode_q_n    = mode;
            level_q_n   = level;
            w_n         = '0;
            fill_wait_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A boundary mid-frame abandons the partial frame and restarts at word 0
    // with the already-latched mode/level.
    if (frame_pulse && (state == FILL || state == STREAM)) begin
      underrun_n  = 1'b1;
      state_n     = FILL;
      w_n         = '0;
      fill_wait_n = 1'b1;
      out_valid_n = 1'b0;
      out_last_n  = 1'b0;
    end

    // Every honoured boundary advances the frame; parity mirrors frame_count[0].
    if (frame_pulse && state != IDLE) begin
      frame_count_n = frame_count + 16'd1;
      bar_n         = (bar == B_LAST) ? '0 : bar + 1'b1;
      parity_n      = ~parity;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      w           <= '0;
      mode_q      <= '0;
      level_q     <= '0;
      bar         <= '0;
      parity      <= 1'b0;
      fill_wait   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      frame_count <= '0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      w           <= w_n;
      mode_q      <= mode_q_n;
      level_q     <= level_q_n;
      bar         <= bar_n;
      parity      <= parity_n;
      fill_wait   <= fill_wait_n;
      out_valid   <= out_valid_n;
      out_data    <= out_data_n;
      out_last    <= out_last_n;
      frame_count <= frame_count_n;
      underrun    <= underrun_n;
    end
  end
endmodule
